tt_cpu_core_param: RTL

//  Parametrised successor to the 4-bit switch-programmed CPU. It holds a loadable program

---
 rtl/tt_cpu_pkg.sv | 20 ++
 rtl/cpu_alu_n.sv | 39 +++
 rtl/tt_cpu_core_param.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/tt_cpu_pkg.sv
// Shared definitions for the parametrised tiny CPU: opcode values and sequencer states.
package tt_cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_IN  = 3'b001;
  localparam logic [2:0] OP_OUT = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_JNZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_alu_n.sv
// Combinational ALU: ADD/SUB/AND/XOR with carry (borrow on SUB) and zero outputs.
module cpu_alu_n
  import tt_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum = '0;
    y     = '0;
    c     = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        y     = w_sum[DATA_W-1:0];
        c     = w_sum[DATA_W];
      end
      OP_SUB: begin
        y = a - b;
        c = (a < b);
      end
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/tt_cpu_core_param.sv
// Parametrised tiny CPU: loadable program memory, register file, FETCH/EXEC sequencer,
// flagged ALU, JNZ, single-step mode and a direction-controlled I/O port.
module tt_cpu_core_param
  import tt_cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PROG_DEPTH = 16,
  parameter int NREG       = 4,
  localparam int ADDR_W    = $clog2(PROG_DEPTH),
  localparam int RSEL_W    = $clog2(NREG),
  localparam int INSTR_W   = 3 + 2*RSEL_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               prog_en,
  input  logic               prog_we,
  input  logic [INSTR_W-1:0] prog_instr,
  input  logic               step_mode,
  input  logic               step,
  input  logic [DATA_W-1:0]  port_in,
  output logic [DATA_W-1:0]  port_out,
  output logic               port_oe,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
  output logic               flag_z,
  output logic               flag_c
);

  localparam int JW = (2*RSEL_W > ADDR_W) ? 2*RSEL_W : ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_ptr;
  logic [INSTR_W-1:0]  r_ir;
  logic [INSTR_W-1:0]  r_mem [PROG_DEPTH];
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_port_out;
  logic                r_port_oe;
  logic                r_flag_z;
  logic                r_flag_c;
  logic                r_step_d;

  logic [2:0]          w_op;
  logic [RSEL_W-1:0]   w_rd;
  logic [RSEL_W-1:0]   w_rs;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu_y;
  logic                w_alu_c;
  logic                w_alu_z;
  logic                w_step_rise;
  logic                w_exec;
  logic                w_load_wr;
  logic                w_reg_we;
  logic [DATA_W-1:0]   w_reg_wdata;
  logic [JW-1:0]       w_jmp_wide;
  logic [ADDR_W-1:0]   w_jmp_tgt;

  assign w_op        = r_ir[INSTR_W-1 -: 3];
  assign w_rd        = r_ir[RSEL_W +: RSEL_W];
  assign w_rs        = r_ir[0 +: RSEL_W];
  assign w_a         = r_regs[w_rd];
  assign w_b         = r_regs[w_rs];
  assign w_step_rise = step & ~r_step_d;
  // prog_en during EXEC aborts the instruction, so every architectural update is gated here.
  assign w_exec      = (r_state == ST_EXEC) && !prog_en;
  assign w_load_wr   = (r_state == ST_LOAD) && prog_en && prog_we;
  assign w_reg_we    = w_exec && ((w_op == OP_IN)  || (w_op == OP_ADD) || (w_op == OP_SUB) ||
                                  (w_op == OP_AND) || (w_op == OP_XOR));
  assign w_reg_wdata = (w_op == OP_IN) ? port_in : w_alu_y;
  assign w_jmp_wide  = JW'({w_rd, w_rs});
  assign w_jmp_tgt   = w_jmp_wide[ADDR_W-1:0];

  cpu_alu_n #(.DATA_W(DATA_W)) u_alu (
    .op (w_op),
    .a  (w_a),
    .b  (w_b),
    .y  (w_alu_y),
    .c  (w_alu_c),
    .z  (w_alu_z)
  );

  always_comb begin
    w_state_next = r_state;
    if (prog_en) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  w_state_next = ST_IDLE;
        ST_IDLE:  if (!step_mode || w_step_rise) w_state_next = ST_FETCH;
        ST_FETCH: w_state_next = ST_EXEC;
        ST_EXEC:  w_state_next = step_mode ? ST_IDLE : ST_FETCH;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state  <= ST_IDLE;
      r_step_d <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_step_d <= step;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_pc  <= '0;
      r_ptr <= '0;
      r_ir  <= '0;
    end else begin
      if (prog_en && (r_state != ST_LOAD)) r_ptr <= '0;
      else if (w_load_wr)                  r_ptr <= r_ptr + ADDR_W'(1);

      if ((r_state == ST_FETCH) && !prog_en) r_ir <= r_mem[r_pc];

      if ((r_state == ST_LOAD) && !prog_en) begin
        r_pc <= '0;
      end else if (w_exec) begin
        if ((w_op == OP_JNZ) && !r_flag_z) r_pc <= w_jmp_tgt;
        else                               r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < PROG_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_load_wr) begin
      r_mem[r_ptr] <= prog_instr;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_reg_we) begin
      r_regs[w_rd] <= w_reg_wdata;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_port_out <= '0;
      r_port_oe  <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
    end else if (w_exec) begin
      case (w_op)
        OP_IN: begin
          r_flag_z  <= (port_in == '0);
          r_port_oe <= 1'b0;
        end
        OP_OUT: begin
          r_port_out <= w_b;
          r_port_oe  <= 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
          r_flag_z <= w_alu_z;
          r_flag_c <= w_alu_c;
        end
        default: ;
      endcase
    end
  end

  assign port_out = r_port_out;
  assign port_oe  = r_port_oe;
  assign pc_out   = r_pc;
  assign busy     = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;

endmodule
